// File: rtl/input_conditioner_pkg.sv
// Shared types and constants for the board input conditioner.
// Used by input_conditioner and button_debounce.
package input_cond_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CNT = 2'd1,
    HELD      = 2'd2,
    REL_CNT   = 2'd3
  } btn_state_t;

endpackage

// File: rtl/input_conditioner_button_debounce.sv
// Single-button conditioner: 2-flop synchronizer, debounce FSM and one-shot press pulse.
// With INPUT_COND_AUTOREPEAT_EN defined, instances with REPEAT_ENABLE=1 auto-repeat while held.
//
// state     | meaning
// IDLE      | released, waiting for the first high sample
// PRESS_CNT | counting consecutive high samples toward acceptance
// HELD      | press accepted (pulse already issued)
// REL_CNT   | counting consecutive low samples toward release
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 16,
  parameter bit REPEAT_ENABLE   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic pulse_o
);
  import input_cond_pkg::*;

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  btn_state_t             state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic                   press_done;
  logic                   rpt_fire;

  assign sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    press_done = 1'b0;
    case (state)
      IDLE: begin
        if (sync) begin
          state_nxt = PRESS_CNT;
          cnt_nxt   = CNT_W'(1);
        end
      end
      PRESS_CNT: begin
        if (!sync) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt  = HELD;
          cnt_nxt    = '0;
          press_done = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HELD: begin
        if (!sync) begin
          state_nxt = REL_CNT;
          cnt_nxt   = CNT_W'(1);
        end
      end
      REL_CNT: begin
        // A high sample mid-release is a glitch: return to HELD without a new pulse.
        if (sync) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      state   <= IDLE;
      cnt     <= '0;
      pulse_o <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_i};
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pulse_o <= press_done | rpt_fire;
    end
  end

`ifdef INPUT_COND_AUTOREPEAT_EN
  if (REPEAT_ENABLE) begin : g_rpt
    localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_stay;

    // Counts only while staying in HELD; any exit or re-entry restarts the interval.
    assign rpt_stay = (state == HELD) && (state_nxt == HELD);
    assign rpt_fire = rpt_stay && (rpt_cnt == RPT_LAST);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rpt_cnt <= '0;
      end else if (rpt_stay && !rpt_fire) begin
        rpt_cnt <= rpt_cnt + 1'b1;
      end else begin
        rpt_cnt <= '0;
      end
    end
  end else begin : g_no_rpt
    logic rpt_cfg_unused;
    assign rpt_cfg_unused = (REPEAT_CYCLES != 0);
    assign rpt_fire       = 1'b0;
  end
`else
  logic rpt_cfg_unused;
  assign rpt_cfg_unused = (REPEAT_CYCLES != 0) ^ REPEAT_ENABLE;
  assign rpt_fire       = 1'b0;
`endif

endmodule

// File: rtl/input_conditioner.sv
// Board input conditioner: one-shot run/continue pulses and a debounced switch word.
// Define INPUT_COND_AUTOREPEAT_EN to enable auto-repeat on a held continue button.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 16,
  parameter int SW_WIDTH        = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run_i,
  input  logic                continue_i,
  input  logic [SW_WIDTH-1:0] sw_i,
  output logic                run_o,
  output logic                continue_o,
  output logic [SW_WIDTH-1:0] sw_o,
  output logic                sw_changed_o
);
  import input_cond_pkg::*;

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_CYCLES   (REPEAT_CYCLES),
    .REPEAT_ENABLE   (1'b0)
  ) u_run (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (run_i),
    .pulse_o (run_o)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_CYCLES   (REPEAT_CYCLES),
    .REPEAT_ENABLE   (1'b1)
  ) u_continue (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (continue_i),
    .pulse_o (continue_o)
  );

  logic [SYNC_STAGES-1:0][SW_WIDTH-1:0] sw_sync_q;
  logic [SW_WIDTH-1:0]                  sw_sync;
  logic [SW_WIDTH-1:0]                  sw_cand;
  logic [CNT_W-1:0]                     sw_cnt, sw_cnt_nxt;
  logic                                 sw_take;

  assign sw_sync = sw_sync_q[SYNC_STAGES-1];

  // Stability counter saturates at the limit; any bit change restarts it.
  always_comb begin
    sw_cnt_nxt = sw_cnt;
    if (sw_sync != sw_cand) begin
      sw_cnt_nxt = '0;
    end else if (sw_cnt != CNT_MAX) begin
      sw_cnt_nxt = sw_cnt + 1'b1;
    end
  end

  assign sw_take = (sw_cnt_nxt == CNT_MAX) && (sw_cand != sw_o);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_sync_q    <= '0;
      sw_cand      <= '0;
      sw_cnt       <= '0;
      sw_o         <= '0;
      sw_changed_o <= 1'b0;
    end else begin
      sw_sync_q    <= {sw_sync_q[SYNC_STAGES-2:0], sw_i};
      sw_cand      <= sw_sync;
      sw_cnt       <= sw_cnt_nxt;
      sw_changed_o <= sw_take;
      if (sw_take) begin
        sw_o <= sw_cand;
      end
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: run-length reference model plus directed vectors.
// Expectations follow INPUT_COND_AUTOREPEAT_EN when it is defined for the build.
module tb_input_conditioner;

  localparam int DB   = 4;
  localparam int RPT  = 16;
  localparam int SW_W = 16;
`ifdef INPUT_COND_AUTOREPEAT_EN
  localparam bit AUTOREP = 1'b1;
`else
  localparam bit AUTOREP = 1'b0;
`endif

  logic            clk        = 1'b0;
  logic            reset      = 1'b0;
  logic            run_i      = 1'b0;
  logic            continue_i = 1'b0;
  logic [SW_W-1:0] sw_i       = '0;
  logic            run_o, continue_o, sw_changed_o;
  logic [SW_W-1:0] sw_o;

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;
  int run_cnt = 0, cont_cnt = 0, chg_cnt = 0;
  int run_last = -1, cont_last = -1, chg_last = -1;

  input_conditioner #(
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_CYCLES   (RPT),
    .SW_WIDTH        (SW_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .run_i        (run_i),
    .continue_i   (continue_i),
    .sw_i         (sw_i),
    .run_o        (run_o),
    .continue_o   (continue_o),
    .sw_o         (sw_o),
    .sw_changed_o (sw_changed_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: a press is accepted after DB+1 consecutive high synchronized
  // samples and released after DB+1 consecutive low ones; switches likewise.
  bit              acc[2];
  int              ones[2];
  int              zeros[2];
  int              rep[2];
  bit              prev_s[2];
  bit              run_q[$];
  bit              cont_q[$];
  logic [SW_W-1:0] sw_q[$];
  bit              exp_run, exp_cont, exp_chg;
  logic [SW_W-1:0] exp_sw = '0;
  logic [SW_W-1:0] sw_prev = '0;
  int              sw_run = 1;

  task automatic btn_step(input int b, input bit s, input bit can_rep, output bit pulse);
    pulse = 1'b0;
    if (s) begin
      ones[b]++;
      zeros[b] = 0;
    end else begin
      zeros[b]++;
      ones[b] = 0;
    end
    if (!acc[b]) begin
      if (ones[b] == DB + 1) begin
        acc[b] = 1'b1;
        pulse  = 1'b1;
        rep[b] = 0;
      end
    end else if (!s) begin
      rep[b] = 0;
      if (zeros[b] == DB + 1) acc[b] = 1'b0;
    end else if (!prev_s[b]) begin
      rep[b] = 0;
    end else begin
      rep[b]++;
      if (can_rep && rep[b] == RPT) begin
        pulse  = 1'b1;
        rep[b] = 0;
      end
    end
    prev_s[b] = s;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q.delete();
      cont_q.delete();
      sw_q.delete();
      for (int b = 0; b < 2; b++) begin
        acc[b] = 1'b0; ones[b] = 0; zeros[b] = 0; rep[b] = 0; prev_s[b] = 1'b0;
      end
      exp_run = 1'b0; exp_cont = 1'b0; exp_chg = 1'b0;
      exp_sw = '0; sw_prev = '0; sw_run = 1;
    end else begin : m_step
      bit              s_run, s_cont;
      logic [SW_W-1:0] w;
      s_run  = (run_q.size()  >= 2) ? run_q[run_q.size()-2]   : 1'b0;
      s_cont = (cont_q.size() >= 2) ? cont_q[cont_q.size()-2] : 1'b0;
      w      = (sw_q.size()   >= 2) ? sw_q[sw_q.size()-2]     : '0;
      run_q.push_back(run_i);
      cont_q.push_back(continue_i);
      sw_q.push_back(sw_i);
      if (run_q.size() > 2)  void'(run_q.pop_front());
      if (cont_q.size() > 2) void'(cont_q.pop_front());
      if (sw_q.size() > 2)   void'(sw_q.pop_front());
      btn_step(0, s_run, 1'b0, exp_run);
      btn_step(1, s_cont, AUTOREP, exp_cont);
      if (w == sw_prev) sw_run++;
      else sw_run = 1;
      sw_prev = w;
      exp_chg = 1'b0;
      if (sw_run >= DB + 1 && w != exp_sw) begin
        exp_sw  = w;
        exp_chg = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    chk("run_o",        int'(run_o),        int'(exp_run));
    chk("continue_o",   int'(continue_o),   int'(exp_cont));
    chk("sw_o",         int'(sw_o),         int'(exp_sw));
    chk("sw_changed_o", int'(sw_changed_o), int'(exp_chg));
    if (run_o)        begin run_cnt++;  run_last  = cyc; end
    if (continue_o)   begin cont_cnt++; cont_last = cyc; end
    if (sw_changed_o) begin chg_cnt++;  chg_last  = cyc; end
  end

  initial begin
    int t, base_r, base_c, base_s;
    logic [5:0] bpat;
    logic [2:0] rpat;
    bpat = 6'b101101;
    rpat = 3'b010;

    tick(3);
    chk("reset_run_o",        int'(run_o),        0);
    chk("reset_continue_o",   int'(continue_o),   0);
    chk("reset_sw_o",         int'(sw_o),         0);
    chk("reset_sw_changed_o", int'(sw_changed_o), 0);
    reset = 1'b1;
    tick(5);

    // clean run press, 10 cycles
    base_r = run_cnt; base_c = cont_cnt;
    run_i = 1'b1; t = cyc + 1;
    tick(10);
    run_i = 1'b0;
    tick(15);
    chk("clean_run_count",   run_cnt - base_r, 1);
    chk("clean_run_latency", run_last, t + 6);
    chk("clean_cont_quiet",  cont_cnt - base_c, 0);

    // bouncy continue press and bouncy release
    base_r = run_cnt; base_c = cont_cnt;
    for (int i = 0; i < 6; i++) begin
      continue_i = bpat[i];
      if (i == 5) t = cyc + 1;
      tick(1);
    end
    tick(9);
    for (int i = 0; i < 3; i++) begin
      continue_i = rpat[i];
      tick(1);
    end
    continue_i = 1'b0;
    tick(15);
    chk("bounce_cont_count",   cont_cnt - base_c, 1);
    chk("bounce_cont_latency", cont_last, t + 6);
    chk("bounce_run_quiet",    run_cnt - base_r, 0);

    // 3-cycle glitch is below the minimum press width
    base_r = run_cnt;
    run_i = 1'b1;
    tick(3);
    run_i = 1'b0;
    tick(12);
    chk("glitch_run_count", run_cnt - base_r, 0);

    // simultaneous presses do not mask each other
    base_r = run_cnt; base_c = cont_cnt;
    run_i = 1'b1; continue_i = 1'b1; t = cyc + 1;
    tick(10);
    run_i = 1'b0; continue_i = 1'b0;
    tick(15);
    chk("simul_run_count",    run_cnt - base_r, 1);
    chk("simul_cont_count",   cont_cnt - base_c, 1);
    chk("simul_run_latency",  run_last, t + 6);
    chk("simul_cont_latency", cont_last, t + 6);

    // switch word change
    base_s = chg_cnt;
    sw_i = 16'h009C; t = cyc + 1;
    tick(15);
    chk("sw_value",      int'(sw_o), 32'h009C);
    chk("sw_chg_count",  chg_cnt - base_s, 1);
    chk("sw_chg_latency", chg_last, t + 6);

    // continuously toggling switches never update
    base_s = chg_cnt;
    for (int k = 0; k < 10; k++) begin
      sw_i = (k % 2 == 0) ? 16'h0056 : 16'h0026;
      tick(2);
    end
    chk("toggle_sw_value",  int'(sw_o), 32'h009C);
    chk("toggle_chg_count", chg_cnt - base_s, 0);
    sw_i = 16'h009C;
    tick(10);
    chk("same_word_no_chg", chg_cnt - base_s, 0);

    // reset in the middle of a press (PRESS_CNT, count 2)
    base_r = run_cnt;
    run_i = 1'b1;
    tick(4);
    reset = 1'b0;
    #1;
    chk("midrst_run_o",        int'(run_o),        0);
    chk("midrst_sw_o",         int'(sw_o),         0);
    chk("midrst_sw_changed_o", int'(sw_changed_o), 0);
    tick(2);
    reset = 1'b1; t = cyc + 1;
    tick(12);
    chk("midrst_run_count",   run_cnt - base_r, 1);
    chk("midrst_run_latency", run_last, t + 6);
    chk("midrst_sw_restored", int'(sw_o), 32'h009C);
    run_i = 1'b0;
    tick(15);

    // long holds: continue may auto-repeat, run never does
    base_c = cont_cnt;
    continue_i = 1'b1; t = cyc + 1;
    tick(60);
    continue_i = 1'b0;
    tick(20);
    chk("hold_cont_count", cont_cnt - base_c, AUTOREP ? 4 : 1);
    chk("hold_cont_last",  cont_last, AUTOREP ? t + 54 : t + 6);

    base_r = run_cnt;
    run_i = 1'b1; t = cyc + 1;
    tick(60);
    run_i = 1'b0;
    tick(20);
    chk("hold_run_count", run_cnt - base_r, 1);
    chk("hold_run_last",  run_last, t + 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Conditions the raw board inputs before they reach processor_top: run_i, continue_i and sw_i.
- Each input passes through a 2-flop synchronizer and is then debounced.
- Each button produces exactly one single-cycle pulse per press, so the processor control FSM never sees a bouncing or multi-cycle run/continue.
- Switches are synchronized and debounced as a 16-bit word, which gives the processor a stable value.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required before a change is accepted. Must be ≥1. The board top overrides it to 500000.
- REPEAT_CYCLES, 16, held-button interval between auto-repeat pulses. Used only with the optional feature.
- SW_WIDTH, 16, switch bus width.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- run_i  input  1  raw run button, asynchronous
- continue_i  input  1  raw continue button, asynchronous
- sw_i  input  SW_WIDTH  raw switches, asynchronous
- run_o  output  1  one-cycle pulse per accepted run press
- continue_o  output  1  one-cycle pulse per accepted continue press
- sw_o  output  SW_WIDTH  debounced switch word
- sw_changed_o  output  1  one-cycle pulse when sw_o updates

Behaviour:
- Reset (reset low, asynchronous):
  - all synchronizer flops, counters, run_o, continue_o, sw_o and sw_changed_o go to 0;
  - both button FSMs go to IDLE.
  - Applies immediately, including mid-press or mid-count. No output pulse is generated by the reset itself.
- Synchronizer: 2 flops per bit. The synchronized value lags the raw input by 2 clk edges.
- Button FSM, one per button, states IDLE / PRESS_CNT / HELD / REL_CNT. Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - IDLE: sync=1 → PRESS_CNT with cnt=1.
  - PRESS_CNT: sync=0 → IDLE with cnt=0. sync=1 and cnt==DEBOUNCE_CYCLES → HELD, otherwise cnt++.
  - Pulse: on the IDLE→... transition into HELD, assert the output for exactly the one cycle following the transition edge.
  - HELD: sync=0 → REL_CNT with cnt=1.
  - REL_CNT: sync=1 → HELD with no new pulse. cnt==DEBOUNCE_CYCLES → IDLE, otherwise cnt++.
- Latency: a raw press held clean from edge t gives its pulse high in cycle t+2+DEBOUNCE_CYCLES (±0). This is 6 cycles at the default, so the 10-cycle bench presses produce exactly one pulse.
- Minimum press width: a press shorter than DEBOUNCE_CYCLES+1 synchronized samples produces no pulse.
- Held through reset: after reset release the FSM starts in IDLE, so a held button produces one pulse after the normal latency.
- Buttons are independent. Simultaneous presses may pulse in the same cycle, and neither masks the other.
- Switch path:
  - Candidate register = synchronized word. Any bit differing from the previous synchronized sample restarts the stability counter at 0.
  - When the counter reaches DEBOUNCE_CYCLES and the candidate ≠ sw_o: sw_o ← candidate and sw_changed_o pulses 1 cycle.
  - The counter saturates and does not wrap.
  - A continuously toggling input never updates sw_o.

Optional Feature:
- Macro: INPUT_COND_AUTOREPEAT_EN.
- Defined: while a button FSM stays in HELD, a repeat counter starts at 0 on HELD entry. Each time it reaches REPEAT_CYCLES it emits a further one-cycle pulse and restarts.
  - Leaving HELD, including the REL_CNT glitch return, clears the repeat counter.
  - Applies to continue only; run never repeats.
- Undefined: the repeat counter and its logic are absent, and exactly one pulse per press is produced.

Decomposition:
- Package input_cond_pkg:
  - typedef enum logic [1:0] btn_state_t {IDLE, PRESS_CNT, HELD, REL_CNT};
  - localparam SYNC_STAGES = 2.
- Sub-module button_debounce (synchronizer, FSM, pulse, optional repeat) is instantiated twice, with a per-instance parameter REPEAT_ENABLE (0 for run, 1 for continue).
- The switch path stays inline in input_conditioner.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=16):
- Clean press: run_i high for 10 cycles from edge t → run_o high only in cycle t+6. Exactly 1 pulse; continue_o stays 0.
- Bounce: continue_i pattern 1,0,1,1,0,1 then held 10 cycles → exactly 1 continue_o pulse, 6 cycles after the final rising sample. Release bounce 0,1,0 then low → no extra pulse.
- Short glitch: run_i high for 3 cycles → run_o never asserts.
- Switches:
  - sw_i 0x0000→0x009C held → sw_o=0x009C and one sw_changed_o pulse, 6 cycles after the change.
  - sw_i toggling 0x0056/0x0026 every 2 cycles → sw_o unchanged.
- Reset mid-operation: run_i held, reset low at PRESS_CNT cnt=2 → run_o=0 and sw_o=0 immediately. After release with run_i still high → one pulse 6 cycles later.
- With INPUT_COND_AUTOREPEAT_EN: continue_i held 60 cycles → pulses at t+6, t+22, t+38, t+54, i.e. 4 total. run_i held 60 cycles → 1 pulse.
